// File: rtl/mips_pipeline_processor.sv
// Five-stage MIPS core (IF/ID/EX/MEM/WB) with forwarding, load-use stall and branch flush.
// Instruction memory is a read-only image supplied through IMEM_INIT (word 0 in the low 32 bits).
module mips_pipeline_processor #(
    parameter int IMEM_WORDS = 64,
    parameter int DMEM_WORDS = 64,
    parameter logic [IMEM_WORDS*32-1:0] IMEM_INIT = '0
) (
    input  logic        clk,
    input  logic        resetManual,
    input  logic [31:0] PCSrcInput,
    output logic [1:0]  CSignal_ForwardingMUX_ALUi0,
    output logic [1:0]  CSignal_ForwardingMUX_ALUi1,
    output logic [31:0] PCOutput,
    output logic [31:0] ALUPCPlus4Output,
    output logic [31:0] instruction,
    output logic        PCWrite,
    output logic        IF_ID_Write,
    output logic        MUX_ID_EX_Write,
    output logic [31:0] PIPE_IFID_ALUPCPlus4Output,
    output logic [31:0] PIPE_IFID_Instruction,
    output logic [31:0] readData1,
    output logic [31:0] readData2,
    output logic [31:0] signExtendOutput,
    output logic        CSignal_RegDst,
    output logic        CSignal_ALUSrc,
    output logic        CSignal_MemtoReg,
    output logic        CSignal_RegWrite,
    output logic        CSignal_MemRead,
    output logic        CSignal_MemWrite,
    output logic        CSignal_Branch,
    output logic [1:0]  CSignal_ALUOp,
    output logic [31:0] PIPE_IDEX_OUT_ALUPCPlus4Output,
    output logic [31:0] PIPE_IDEX_OUT_ReadData1,
    output logic [31:0] PIPE_IDEX_OUT_ReadData2,
    output logic [31:0] PIPE_IDEX_OUT_SignExt,
    output logic [4:0]  PIPE_IDEX_OUT_RS,
    output logic [4:0]  PIPE_IDEX_OUT_RT,
    output logic [4:0]  PIPE_IDEX_OUT_RD,
    output logic        PIPE_IDEX_OUT_CSignal_EX_RegDst,
    output logic        PIPE_IDEX_OUT_CSignal_EX_ALUSrc,
    output logic        PIPE_IDEX_OUT_CSignal_WB_MemtoReg,
    output logic        PIPE_IDEX_OUT_CSignal_WB_RegWrite,
    output logic        PIPE_IDEX_OUT_CSignal_MEM_MRead,
    output logic        PIPE_IDEX_OUT_CSignal_MEM_MWrite,
    output logic        PIPE_IDEX_OUT_CSignal_MEM_Branch,
    output logic [1:0]  PIPE_IDEX_OUT_CSignal_EX_ALUOp,
    output logic [31:0] sllOutput,
    output logic [31:0] branchALUOutput,
    output logic [31:0] ALUSrcOutput,
    output logic [31:0] forwardingMUXALUi0,
    output logic [31:0] forwardingMUXALUi1,
    output logic [31:0] mainALUOutput,
    output logic        zero,
    output logic [3:0]  ALUControlOutput,
    output logic [4:0]  regDstOutput,
    output logic        PIPE_EXMEM_OUT_CSignal_WB_MemtoReg,
    output logic        PIPE_EXMEM_OUT_CSignal_WB_RegWrite,
    output logic        PIPE_EXMEM_OUT_CSignal_MEM_MRead,
    output logic        PIPE_EXMEM_OUT_CSignal_MEM_MWrite,
    output logic        PIPE_EXMEM_OUT_CSignal_MEM_Branch,
    output logic        PIPE_EXMEM_OUT_Zero,
    output logic [31:0] PIPE_EXMEM_OUT_BranchALUOutput,
    output logic [31:0] PIPE_EXMEM_OUT_MainALUOutput,
    output logic [31:0] PIPE_EXMEM_OUT_ReadData2,
    output logic [4:0]  PIPE_EXMEM_OUT_RegDstOutput,
    output logic [31:0] dataMemoryOutput,
    output logic        branchGateOutput,
    output logic        PIPE_MEMWB_OUT_CSignal_MemtoReg,
    output logic        PIPE_MEMWB_OUT_CSignal_RegWrite,
    output logic [31:0] PIPE_MEMWB_DataMemoryOutput,
    output logic [31:0] PIPE_MEMWB_MainALUOutput,
    output logic [4:0]  PIPE_MEMWB_RegDstOutput,
    output logic [31:0] memtoRegOutput
);

    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);

    // ---------------- IF ----------------
    logic [31:0] r_pc;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_instr;
    logic [31:0] w_imem [IMEM_WORDS];

    for (genvar g = 0; g < IMEM_WORDS; g++) begin : g_imem
        assign w_imem[g] = IMEM_INIT[g*32 +: 32];
    end

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_instr    = w_imem[r_pc[IAW+1:2]];

    // ---------------- IF/ID -> ID ----------------
    logic [31:0] r_ifid_pc4, r_ifid_instr;
    logic [5:0]  w_op;
    logic [4:0]  w_rs, w_rt, w_rd;
    logic [31:0] w_sext, w_rd1, w_rd2;
    logic        w_regdst, w_alusrc, w_memtoreg, w_regwrite;
    logic        w_memread, w_memwrite, w_branch;
    logic [1:0]  w_aluop;
    logic        w_stall;
    logic [31:0] r_regs [32];

    assign w_op   = r_ifid_instr[31:26];
    assign w_rs   = r_ifid_instr[25:21];
    assign w_rt   = r_ifid_instr[20:16];
    assign w_rd   = r_ifid_instr[15:11];
    assign w_sext = {{16{r_ifid_instr[15]}}, r_ifid_instr[15:0]};

    always_comb begin
        w_regdst   = 1'b0;
        w_alusrc   = 1'b0;
        w_memtoreg = 1'b0;
        w_regwrite = 1'b0;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        w_branch   = 1'b0;
        w_aluop    = 2'b00;
        case (w_op)
            6'h00: begin
                w_regdst   = 1'b1;
                w_regwrite = 1'b1;
                w_aluop    = 2'b10;
            end
            6'h23: begin
                w_alusrc   = 1'b1;
                w_memtoreg = 1'b1;
                w_regwrite = 1'b1;
                w_memread  = 1'b1;
            end
            6'h2B: begin
                w_alusrc   = 1'b1;
                w_memwrite = 1'b1;
            end
            6'h04: begin
                w_branch = 1'b1;
                w_aluop  = 2'b01;
            end
            default: ;
        endcase
    end

    // ID/EX register-number fields and MEM/WB signals used by hazard/bypass logic
    logic [31:0] r_idex_pc4, r_idex_rd1, r_idex_rd2, r_idex_sext;
    logic [4:0]  r_idex_rs, r_idex_rt, r_idex_rd;
    logic        r_idex_regdst, r_idex_alusrc, r_idex_memtoreg, r_idex_regwrite;
    logic        r_idex_memread, r_idex_memwrite, r_idex_branch;
    logic [1:0]  r_idex_aluop;
    logic        r_memwb_memtoreg, r_memwb_regwrite;
    logic [31:0] r_memwb_dmem, r_memwb_alu;
    logic [4:0]  r_memwb_dst;
    logic [31:0] w_wb_data;
    logic        w_wb_we;

    assign w_wb_we   = r_memwb_regwrite && (r_memwb_dst != 5'd0);
    assign w_wb_data = r_memwb_memtoreg ? r_memwb_dmem : r_memwb_alu;

    // Write-through so an instruction in ID sees the value being written back this cycle
    assign w_rd1 = (w_rs == 5'd0) ? 32'd0 :
                   (w_wb_we && r_memwb_dst == w_rs) ? w_wb_data : r_regs[w_rs];
    assign w_rd2 = (w_rt == 5'd0) ? 32'd0 :
                   (w_wb_we && r_memwb_dst == w_rt) ? w_wb_data : r_regs[w_rt];

    assign w_stall = r_idex_memread && ((r_idex_rt == w_rs) || (r_idex_rt == w_rt));

    // ---------------- EX ----------------
    logic        r_exmem_memtoreg, r_exmem_regwrite, r_exmem_memread;
    logic        r_exmem_memwrite, r_exmem_branch, r_exmem_zero;
    logic [31:0] r_exmem_btarget, r_exmem_alu, r_exmem_rd2;
    logic [4:0]  r_exmem_dst;
    logic [31:0] w_sll, w_btarget, w_alu_a, w_alu_b_reg, w_alu_b, w_alu_res;
    logic [1:0]  w_fwd_a, w_fwd_b;
    logic [3:0]  w_aluctl;
    logic [4:0]  w_dst;
    logic        w_zero;

    assign w_sll     = {r_idex_sext[29:0], 2'b00};
    assign w_btarget = r_idex_pc4 + w_sll;
    assign w_dst     = r_idex_regdst ? r_idex_rd : r_idex_rt;

    always_comb begin
        w_fwd_a = 2'b00;
        w_fwd_b = 2'b00;
        if (r_exmem_regwrite && r_exmem_dst != 5'd0 && r_exmem_dst == r_idex_rs)
            w_fwd_a = 2'b10;
        else if (w_wb_we && r_memwb_dst == r_idex_rs)
            w_fwd_a = 2'b01;
        if (r_exmem_regwrite && r_exmem_dst != 5'd0 && r_exmem_dst == r_idex_rt)
            w_fwd_b = 2'b10;
        else if (w_wb_we && r_memwb_dst == r_idex_rt)
            w_fwd_b = 2'b01;
    end

    always_comb begin
        case (w_fwd_a)
            2'b10:   w_alu_a = r_exmem_alu;
            2'b01:   w_alu_a = w_wb_data;
            default: w_alu_a = r_idex_rd1;
        endcase
        case (w_fwd_b)
            2'b10:   w_alu_b_reg = r_exmem_alu;
            2'b01:   w_alu_b_reg = w_wb_data;
            default: w_alu_b_reg = r_idex_rd2;
        endcase
    end

    assign w_alu_b = r_idex_alusrc ? r_idex_sext : w_alu_b_reg;

    always_comb begin
        w_aluctl = 4'b1111;
        case (r_idex_aluop)
            2'b00: w_aluctl = 4'b0010;
            2'b01: w_aluctl = 4'b0110;
            2'b10: begin
                case (r_idex_sext[5:0])
                    6'h20:   w_aluctl = 4'b0010;
                    6'h22:   w_aluctl = 4'b0110;
                    6'h24:   w_aluctl = 4'b0000;
                    6'h25:   w_aluctl = 4'b0001;
                    6'h2A:   w_aluctl = 4'b0111;
                    default: w_aluctl = 4'b1111;
                endcase
            end
            default: w_aluctl = 4'b1111;
        endcase
    end

    always_comb begin
        case (w_aluctl)
            4'b0000: w_alu_res = w_alu_a & w_alu_b;
            4'b0001: w_alu_res = w_alu_a | w_alu_b;
            4'b0010: w_alu_res = w_alu_a + w_alu_b;
            4'b0110: w_alu_res = w_alu_a - w_alu_b;
            4'b0111: w_alu_res = ($signed(w_alu_a) < $signed(w_alu_b)) ? 32'd1 : 32'd0;
            default: w_alu_res = 32'd0;
        endcase
    end

    assign w_zero = (w_alu_res == 32'd0);

    // ---------------- MEM ----------------
    logic [31:0] r_dmem [DMEM_WORDS];
    logic [31:0] w_dmem_rdata;
    logic        w_taken;

    assign w_dmem_rdata = r_exmem_memread ? r_dmem[r_exmem_alu[DAW+1:2]] : 32'd0;
    assign w_taken      = r_exmem_branch & r_exmem_zero;

    always_ff @(posedge clk) begin
        if (r_exmem_memwrite)
            r_dmem[r_exmem_alu[DAW+1:2]] <= r_exmem_rd2;
    end

    // ---------------- state update; a taken branch overrides a stall ----------------
    always_ff @(posedge clk or negedge resetManual) begin
        if (!resetManual) begin
            r_pc         <= 32'd0;
            r_ifid_pc4   <= 32'd0;
            r_ifid_instr <= 32'd0;
        end else if (w_taken) begin
            r_pc         <= r_exmem_btarget;
            r_ifid_pc4   <= 32'd0;
            r_ifid_instr <= 32'd0;
        end else if (!w_stall) begin
            r_pc         <= w_pc_plus4;
            r_ifid_pc4   <= w_pc_plus4;
            r_ifid_instr <= w_instr;
        end
    end

    always_ff @(posedge clk or negedge resetManual) begin
        if (!resetManual || w_taken) begin
            r_idex_pc4      <= 32'd0;
            r_idex_rd1      <= 32'd0;
            r_idex_rd2      <= 32'd0;
            r_idex_sext     <= 32'd0;
            r_idex_rs       <= 5'd0;
            r_idex_rt       <= 5'd0;
            r_idex_rd       <= 5'd0;
            r_idex_regdst   <= 1'b0;
            r_idex_alusrc   <= 1'b0;
            r_idex_memtoreg <= 1'b0;
            r_idex_regwrite <= 1'b0;
            r_idex_memread  <= 1'b0;
            r_idex_memwrite <= 1'b0;
            r_idex_branch   <= 1'b0;
            r_idex_aluop    <= 2'b00;
        end else begin
            r_idex_pc4      <= r_ifid_pc4;
            r_idex_rd1      <= w_rd1;
            r_idex_rd2      <= w_rd2;
            r_idex_sext     <= w_sext;
            r_idex_rs       <= w_rs;
            r_idex_rt       <= w_rt;
            r_idex_rd       <= w_rd;
            r_idex_regdst   <= w_stall ? 1'b0 : w_regdst;
            r_idex_alusrc   <= w_stall ? 1'b0 : w_alusrc;
            r_idex_memtoreg <= w_stall ? 1'b0 : w_memtoreg;
            r_idex_regwrite <= w_stall ? 1'b0 : w_regwrite;
            r_idex_memread  <= w_stall ? 1'b0 : w_memread;
            r_idex_memwrite <= w_stall ? 1'b0 : w_memwrite;
            r_idex_branch   <= w_stall ? 1'b0 : w_branch;
            r_idex_aluop    <= w_stall ? 2'b00 : w_aluop;
        end
    end

    always_ff @(posedge clk or negedge resetManual) begin
        if (!resetManual || w_taken) begin
            r_exmem_memtoreg <= 1'b0;
            r_exmem_regwrite <= 1'b0;
            r_exmem_memread  <= 1'b0;
            r_exmem_memwrite <= 1'b0;
            r_exmem_branch   <= 1'b0;
            r_exmem_zero     <= 1'b0;
            r_exmem_btarget  <= 32'd0;
            r_exmem_alu      <= 32'd0;
            r_exmem_rd2      <= 32'd0;
            r_exmem_dst      <= 5'd0;
        end else begin
            r_exmem_memtoreg <= r_idex_memtoreg;
            r_exmem_regwrite <= r_idex_regwrite;
            r_exmem_memread  <= r_idex_memread;
            r_exmem_memwrite <= r_idex_memwrite;
            r_exmem_branch   <= r_idex_branch;
            r_exmem_zero     <= w_zero;
            r_exmem_btarget  <= w_btarget;
            r_exmem_alu      <= w_alu_res;
            r_exmem_rd2      <= w_alu_b_reg;
            r_exmem_dst      <= w_dst;
        end
    end

    always_ff @(posedge clk or negedge resetManual) begin
        if (!resetManual) begin
            r_memwb_memtoreg <= 1'b0;
            r_memwb_regwrite <= 1'b0;
            r_memwb_dmem     <= 32'd0;
            r_memwb_alu      <= 32'd0;
            r_memwb_dst      <= 5'd0;
        end else begin
            r_memwb_memtoreg <= r_exmem_memtoreg;
            r_memwb_regwrite <= r_exmem_regwrite;
            r_memwb_dmem     <= w_dmem_rdata;
            r_memwb_alu      <= r_exmem_alu;
            r_memwb_dst      <= r_exmem_dst;
        end
    end

    // Register file resets to r[i] = i
    always_ff @(posedge clk or negedge resetManual) begin
        if (!resetManual) begin
            for (int i = 0; i < 32; i++)
                r_regs[i] <= 32'(i);
        end else if (w_wb_we) begin
            r_regs[r_memwb_dst] <= w_wb_data;
        end
    end

    logic w_unused;
    assign w_unused = ^PCSrcInput;

    // ---------------- debug outputs ----------------
    assign CSignal_ForwardingMUX_ALUi0 = w_fwd_a;
    assign CSignal_ForwardingMUX_ALUi1 = w_fwd_b;
    assign PCOutput                    = r_pc;
    assign ALUPCPlus4Output            = w_pc_plus4;
    assign instruction                 = w_instr;
    assign PCWrite                     = ~w_stall;
    assign IF_ID_Write                 = ~w_stall;
    assign MUX_ID_EX_Write             = w_stall;
    assign PIPE_IFID_ALUPCPlus4Output  = r_ifid_pc4;
    assign PIPE_IFID_Instruction       = r_ifid_instr;
    assign readData1                   = w_rd1;
    assign readData2                   = w_rd2;
    assign signExtendOutput            = w_sext;
    assign CSignal_RegDst              = w_regdst;
    assign CSignal_ALUSrc              = w_alusrc;
    assign CSignal_MemtoReg            = w_memtoreg;
    assign CSignal_RegWrite            = w_regwrite;
    assign CSignal_MemRead             = w_memread;
    assign CSignal_MemWrite            = w_memwrite;
    assign CSignal_Branch              = w_branch;
    assign CSignal_ALUOp               = w_aluop;
    assign PIPE_IDEX_OUT_ALUPCPlus4Output    = r_idex_pc4;
    assign PIPE_IDEX_OUT_ReadData1           = r_idex_rd1;
    assign PIPE_IDEX_OUT_ReadData2           = r_idex_rd2;
    assign PIPE_IDEX_OUT_SignExt             = r_idex_sext;
    assign PIPE_IDEX_OUT_RS                  = r_idex_rs;
    assign PIPE_IDEX_OUT_RT                  = r_idex_rt;
    assign PIPE_IDEX_OUT_RD                  = r_idex_rd;
    assign PIPE_IDEX_OUT_CSignal_EX_RegDst   = r_idex_regdst;
    assign PIPE_IDEX_OUT_CSignal_EX_ALUSrc   = r_idex_alusrc;
    assign PIPE_IDEX_OUT_CSignal_WB_MemtoReg = r_idex_memtoreg;
    assign PIPE_IDEX_OUT_CSignal_WB_RegWrite = r_idex_regwrite;
    assign PIPE_IDEX_OUT_CSignal_MEM_MRead   = r_idex_memread;
    assign PIPE_IDEX_OUT_CSignal_MEM_MWrite  = r_idex_memwrite;
    assign PIPE_IDEX_OUT_CSignal_MEM_Branch  = r_idex_branch;
    assign PIPE_IDEX_OUT_CSignal_EX_ALUOp    = r_idex_aluop;
    assign sllOutput          = w_sll;
    assign branchALUOutput    = w_btarget;
    assign ALUSrcOutput       = w_alu_b;
    assign forwardingMUXALUi0 = w_alu_a;
    assign forwardingMUXALUi1 = w_alu_b_reg;
    assign mainALUOutput      = w_alu_res;
    assign zero               = w_zero;
    assign ALUControlOutput   = w_aluctl;
    assign regDstOutput       = w_dst;
    assign PIPE_EXMEM_OUT_CSignal_WB_MemtoReg = r_exmem_memtoreg;
    assign PIPE_EXMEM_OUT_CSignal_WB_RegWrite = r_exmem_regwrite;
    assign PIPE_EXMEM_OUT_CSignal_MEM_MRead   = r_exmem_memread;
    assign PIPE_EXMEM_OUT_CSignal_MEM_MWrite  = r_exmem_memwrite;
    assign PIPE_EXMEM_OUT_CSignal_MEM_Branch  = r_exmem_branch;
    assign PIPE_EXMEM_OUT_Zero                = r_exmem_zero;
    assign PIPE_EXMEM_OUT_BranchALUOutput     = r_exmem_btarget;
    assign PIPE_EXMEM_OUT_MainALUOutput       = r_exmem_alu;
    assign PIPE_EXMEM_OUT_ReadData2           = r_exmem_rd2;
    assign PIPE_EXMEM_OUT_RegDstOutput        = r_exmem_dst;
    assign dataMemoryOutput                   = w_dmem_rdata;
    assign branchGateOutput                   = w_taken;
    assign PIPE_MEMWB_OUT_CSignal_MemtoReg    = r_memwb_memtoreg;
    assign PIPE_MEMWB_OUT_CSignal_RegWrite    = r_memwb_regwrite;
    assign PIPE_MEMWB_DataMemoryOutput        = r_memwb_dmem;
    assign PIPE_MEMWB_MainALUOutput           = r_memwb_alu;
    assign PIPE_MEMWB_RegDstOutput            = r_memwb_dst;
    assign memtoRegOutput                     = w_wb_data;

endmodule

// File: tb/tb_mips_pipeline_processor.sv
// Directed program run through the core; writebacks are checked against a scoreboard queue.
module tb_mips_pipeline_processor;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Word 0 in the low bits; words 18..63 are zero
    localparam logic [64*32-1:0] PROG = {
        {(46*32){1'b0}},
        enc_i(6'h04, 5'd1, 5'd2, 16'd1),      // 68 beq r1,r2,+1 (not taken)
        enc_r(5'd13, 5'd0, 5'd14, 6'h2A),     // 64 slt r14,r13,r0
        enc_r(5'd0, 5'd1, 5'd13, 6'h22),      // 60 sub r13,r0,r1
        enc_r(5'd3, 5'd2, 5'd12, 6'h24),      // 56 and r12,r3,r2
        enc_r(5'd1, 5'd2, 5'd11, 6'h25),      // 52 or  r11,r1,r2
        enc_r(5'd7, 5'd7, 5'd15, 6'h20),      // 48 add r15,r7,r7
        enc_r(5'd1, 5'd2, 5'd10, 6'h2A),      // 44 slt r10,r1,r2
        enc_r(5'd3, 5'd3, 5'd9, 6'h24),       // 40 and r9,r3,r3
        enc_i(6'h23, 5'd0, 5'd7, 16'd4),      // 36 lw r7,4(r0)
        enc_i(6'h2B, 5'd0, 5'd2, 16'd4),      // 32 sw r2,4(r0)
        enc_r(5'd5, 5'd1, 5'd6, 6'h20),       // 28 add r6,r5,r1
        enc_i(6'h23, 5'd0, 5'd5, 16'd0),      // 24 lw r5,0(r0)
        enc_i(6'h2B, 5'd0, 5'd7, 16'd0),      // 20 sw r7,0(r0)
        enc_r(5'd3, 5'd1, 5'd4, 6'h22),       // 16 sub r4,r3,r1
        enc_r(5'd1, 5'd2, 5'd3, 6'h20),       // 12 add r3,r1,r2
        enc_r(5'd1, 5'd1, 5'd20, 6'h20),      //  8 add r20,r1,r1 (must be flushed)
        enc_r(5'd1, 5'd1, 5'd20, 6'h20),      //  4 add r20,r1,r1 (must be flushed)
        enc_i(6'h04, 5'd1, 5'd1, 16'd2)       //  0 beq r1,r1,+2
    };

    logic        clk = 1'b0;
    logic        resetManual;
    logic [31:0] PCSrcInput;
    logic [1:0]  fwdA, fwdB;
    logic [31:0] PCOutput, ALUPCPlus4Output, instruction;
    logic        PCWrite, IF_ID_Write, MUX_ID_EX_Write;
    logic [31:0] ifid_pc4, ifid_instr, readData1, readData2, signExtendOutput;
    logic        c_regdst, c_alusrc, c_memtoreg, c_regwrite, c_memread, c_memwrite, c_branch;
    logic [1:0]  c_aluop;
    logic [31:0] idex_pc4, idex_rd1, idex_rd2, idex_sext;
    logic [4:0]  idex_rs, idex_rt, idex_rd;
    logic        idex_regdst, idex_alusrc, idex_memtoreg, idex_regwrite;
    logic        idex_mread, idex_mwrite, idex_branch;
    logic [1:0]  idex_aluop;
    logic [31:0] sllOutput, branchALUOutput, ALUSrcOutput, fwdMuxA, fwdMuxB, mainALUOutput;
    logic        zero;
    logic [3:0]  ALUControlOutput;
    logic [4:0]  regDstOutput;
    logic        exmem_memtoreg, exmem_regwrite, exmem_mread, exmem_mwrite, exmem_branch, exmem_zero;
    logic [31:0] exmem_btarget, exmem_alu, exmem_rd2;
    logic [4:0]  exmem_dst;
    logic [31:0] dataMemoryOutput;
    logic        branchGateOutput;
    logic        memwb_memtoreg, memwb_regwrite;
    logic [31:0] memwb_dmem, memwb_alu;
    logic [4:0]  memwb_dst;
    logic [31:0] memtoRegOutput;

    mips_pipeline_processor #(
        .IMEM_WORDS(64),
        .DMEM_WORDS(64),
        .IMEM_INIT (PROG)
    ) dut (
        .clk                                (clk),
        .resetManual                        (resetManual),
        .PCSrcInput                         (PCSrcInput),
        .CSignal_ForwardingMUX_ALUi0        (fwdA),
        .CSignal_ForwardingMUX_ALUi1        (fwdB),
        .PCOutput                           (PCOutput),
        .ALUPCPlus4Output                   (ALUPCPlus4Output),
        .instruction                        (instruction),
        .PCWrite                            (PCWrite),
        .IF_ID_Write                        (IF_ID_Write),
        .MUX_ID_EX_Write                    (MUX_ID_EX_Write),
        .PIPE_IFID_ALUPCPlus4Output         (ifid_pc4),
        .PIPE_IFID_Instruction              (ifid_instr),
        .readData1                          (readData1),
        .readData2                          (readData2),
        .signExtendOutput                   (signExtendOutput),
        .CSignal_RegDst                     (c_regdst),
        .CSignal_ALUSrc                     (c_alusrc),
        .CSignal_MemtoReg                   (c_memtoreg),
        .CSignal_RegWrite                   (c_regwrite),
        .CSignal_MemRead                    (c_memread),
        .CSignal_MemWrite                   (c_memwrite),
        .CSignal_Branch                     (c_branch),
        .CSignal_ALUOp                      (c_aluop),
        .PIPE_IDEX_OUT_ALUPCPlus4Output     (idex_pc4),
        .PIPE_IDEX_OUT_ReadData1            (idex_rd1),
        .PIPE_IDEX_OUT_ReadData2            (idex_rd2),
        .PIPE_IDEX_OUT_SignExt              (idex_sext),
        .PIPE_IDEX_OUT_RS                   (idex_rs),
        .PIPE_IDEX_OUT_RT                   (idex_rt),
        .PIPE_IDEX_OUT_RD                   (idex_rd),
        .PIPE_IDEX_OUT_CSignal_EX_RegDst    (idex_regdst),
        .PIPE_IDEX_OUT_CSignal_EX_ALUSrc    (idex_alusrc),
        .PIPE_IDEX_OUT_CSignal_WB_MemtoReg  (idex_memtoreg),
        .PIPE_IDEX_OUT_CSignal_WB_RegWrite  (idex_regwrite),
        .PIPE_IDEX_OUT_CSignal_MEM_MRead    (idex_mread),
        .PIPE_IDEX_OUT_CSignal_MEM_MWrite   (idex_mwrite),
        .PIPE_IDEX_OUT_CSignal_MEM_Branch   (idex_branch),
        .PIPE_IDEX_OUT_CSignal_EX_ALUOp     (idex_aluop),
        .sllOutput                          (sllOutput),
        .branchALUOutput                    (branchALUOutput),
        .ALUSrcOutput                       (ALUSrcOutput),
        .forwardingMUXALUi0                 (fwdMuxA),
        .forwardingMUXALUi1                 (fwdMuxB),
        .mainALUOutput                      (mainALUOutput),
        .zero                               (zero),
        .ALUControlOutput                   (ALUControlOutput),
        .regDstOutput                       (regDstOutput),
        .PIPE_EXMEM_OUT_CSignal_WB_MemtoReg (exmem_memtoreg),
        .PIPE_EXMEM_OUT_CSignal_WB_RegWrite (exmem_regwrite),
        .PIPE_EXMEM_OUT_CSignal_MEM_MRead   (exmem_mread),
        .PIPE_EXMEM_OUT_CSignal_MEM_MWrite  (exmem_mwrite),
        .PIPE_EXMEM_OUT_CSignal_MEM_Branch  (exmem_branch),
        .PIPE_EXMEM_OUT_Zero                (exmem_zero),
        .PIPE_EXMEM_OUT_BranchALUOutput     (exmem_btarget),
        .PIPE_EXMEM_OUT_MainALUOutput       (exmem_alu),
        .PIPE_EXMEM_OUT_ReadData2           (exmem_rd2),
        .PIPE_EXMEM_OUT_RegDstOutput        (exmem_dst),
        .dataMemoryOutput                   (dataMemoryOutput),
        .branchGateOutput                   (branchGateOutput),
        .PIPE_MEMWB_OUT_CSignal_MemtoReg    (memwb_memtoreg),
        .PIPE_MEMWB_OUT_CSignal_RegWrite    (memwb_regwrite),
        .PIPE_MEMWB_DataMemoryOutput        (memwb_dmem),
        .PIPE_MEMWB_MainALUOutput           (memwb_alu),
        .PIPE_MEMWB_RegDstOutput            (memwb_dst),
        .memtoRegOutput                     (memtoRegOutput)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [36:0] sb [$];   // {dst, data} of expected register writebacks, in order

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_wb();
        logic [36:0] e;
        if (memwb_regwrite && memwb_dst != 5'd0) begin
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL wb_unexpected at cycle %0d: observed dst %0d data %0h expected none",
                       cyc, memwb_dst, memtoRegOutput);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("wb_dst", 32'(memwb_dst), 32'(e[36:32]));
                chk("wb_data", memtoRegOutput, e[31:0]);
            end
        end
    endtask

    // Advance to the cycle after edge n, checking writebacks on the way
    task automatic step_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
            cyc++;
            check_wb();
        end
    endtask

    initial begin
        resetManual = 1'b0;
        PCSrcInput  = 32'hDEAD_BEEF;
        sb.push_back({5'd3,  32'd3});
        sb.push_back({5'd4,  32'd2});
        sb.push_back({5'd5,  32'd7});
        sb.push_back({5'd6,  32'd8});
        sb.push_back({5'd7,  32'd2});
        sb.push_back({5'd9,  32'd3});
        sb.push_back({5'd10, 32'd1});
        sb.push_back({5'd15, 32'd4});
        sb.push_back({5'd11, 32'd3});
        sb.push_back({5'd12, 32'd2});
        sb.push_back({5'd13, 32'hFFFF_FFFF});
        sb.push_back({5'd14, 32'd1});

        #22;
        resetManual = 1'b1;
        #1;
        chk("rst_pc", PCOutput, 32'd0);
        chk("rst_ifid_instr", ifid_instr, 32'd0);
        chk("rst_ifid_pc4", ifid_pc4, 32'd0);
        chk("rst_idex_rd1", idex_rd1, 32'd0);
        chk("rst_idex_rd", 32'(idex_rd), 32'd0);
        chk("rst_exmem_alu", exmem_alu, 32'd0);
        chk("rst_memwb_we", 32'(memwb_regwrite), 32'd0);
        chk("fetch_word0", instruction, PROG[31:0]);

        step_to(1);
        chk("pc_after_edge1", PCOutput, 32'd4);
        chk("ifid_beq", ifid_instr, PROG[31:0]);

        step_to(3);
        chk("beq_gate", 32'(branchGateOutput), 32'd1);
        chk("beq_target", exmem_btarget, 32'd12);

        step_to(4);
        chk("beq_pc", PCOutput, 32'd12);
        chk("flush_ifid", ifid_instr, 32'd0);
        chk("flush_idex_rd", 32'(idex_rd), 32'd0);
        chk("flush_idex_we", 32'(idex_regwrite), 32'd0);
        chk("flush_exmem_br", 32'(exmem_branch), 32'd0);

        step_to(7);
        chk("sub_fwdA", 32'(fwdA), 32'd2);
        chk("sub_alu", mainALUOutput, 32'd2);

        step_to(8);
        chk("add_wb_data", memtoRegOutput, 32'd3);
        chk("add_wb_dst", 32'(memwb_dst), 32'd3);

        step_to(9);
        chk("stall_pcwrite", 32'(PCWrite), 32'd0);
        chk("stall_ifidw", 32'(IF_ID_Write), 32'd0);
        chk("stall_bubble", 32'(MUX_ID_EX_Write), 32'd1);
        chk("stall_pc", PCOutput, 32'd32);

        step_to(10);
        chk("post_stall_pcwrite", 32'(PCWrite), 32'd1);
        chk("post_stall_bubble", 32'(MUX_ID_EX_Write), 32'd0);
        chk("post_stall_pc", PCOutput, 32'd32);
        chk("bubble_idex_we", 32'(idex_regwrite), 32'd0);

        step_to(11);
        chk("lu_fwdA", 32'(fwdA), 32'd1);
        chk("lu_alu", mainALUOutput, 32'd8);

        step_to(13);
        chk("read_r3", readData1, 32'd3);

        step_to(14);
        chk("lw_dmem", dataMemoryOutput, 32'd2);

        step_to(15);
        chk("bypass_r7", readData1, 32'd2);
        chk("lw_wb_data", memtoRegOutput, 32'd2);
        chk("lw_wb_dst", 32'(memwb_dst), 32'd7);

        step_to(22);
        chk("bne_branch", 32'(exmem_branch), 32'd1);
        chk("bne_gate", 32'(branchGateOutput), 32'd0);

        step_to(23);
        chk("bne_pc", PCOutput, 32'd84);

        step_to(27);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        #2;
        resetManual = 1'b0;
        #1;
        chk("async_rst_pc", PCOutput, 32'd0);
        chk("async_rst_ifid", ifid_pc4, 32'd0);
        chk("async_rst_memwb", memwb_alu, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_pipeline_processor.md
# mips_pipeline_processor

Five-stage MIPS pipeline: IF, ID, EX, MEM, WB. It contains instruction memory, register file, data memory, a forwarding unit and a load-use hazard unit. It is the top-level CPU core of the design. Every pipeline register and datapath node is brought out as a debug output so benches can trace each stage every cycle.

## Interface
Parameters:
- IMEM_WORDS, 64: instruction memory depth in 32-bit words; indexed by PC[7:2].
- DMEM_WORDS, 64: data memory depth in words; indexed by address[7:2].

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- resetManual  in  1  reset; asynchronous, active-low.
- PCSrcInput  in  32  reserved; ignored by the logic.
- CSignal_ForwardingMUX_ALUi0 / _ALUi1  out  2  ForwardA / ForwardB selects.
- PCOutput, ALUPCPlus4Output, instruction  out  32  IF: PC, PC+4, fetched word.
- PCWrite, IF_ID_Write, MUX_ID_EX_Write  out  1  hazard unit outputs; MUX_ID_EX_Write=1 inserts a bubble.
- PIPE_IFID_ALUPCPlus4Output, PIPE_IFID_Instruction  out  32  IF/ID register contents.
- readData1, readData2, signExtendOutput  out  32  ID read ports and sign-extended imm[15:0].
- CSignal_RegDst, _ALUSrc, _MemtoReg, _RegWrite, _MemRead, _MemWrite, _Branch  out  1  raw decoder outputs, before the bubble mux.
- CSignal_ALUOp  out  2  raw decoder output.
- PIPE_IDEX_OUT_ALUPCPlus4Output, _ReadData1, _ReadData2, _SignExt  out  32  ID/EX data.
- PIPE_IDEX_OUT_RS, _RT, _RD  out  5  ID/EX register numbers.
- PIPE_IDEX_OUT_CSignal_EX_RegDst, _EX_ALUSrc, _WB_MemtoReg, _WB_RegWrite, _MEM_MRead, _MEM_MWrite, _MEM_Branch  out  1  ID/EX control.
- PIPE_IDEX_OUT_CSignal_EX_ALUOp  out  2  ID/EX control.
- sllOutput, branchALUOutput, ALUSrcOutput, forwardingMUXALUi0, forwardingMUXALUi1, mainALUOutput  out  32  EX nodes.
- zero  out  1  EX node.
- ALUControlOutput  out  4  EX node.
- regDstOutput  out  5  EX node.
- PIPE_EXMEM_OUT_CSignal_WB_MemtoReg, _WB_RegWrite, _MEM_MRead, _MEM_MWrite, _MEM_Branch, PIPE_EXMEM_OUT_Zero  out  1  EX/MEM register.
- PIPE_EXMEM_OUT_BranchALUOutput, _MainALUOutput, _ReadData2  out  32  EX/MEM register.
- PIPE_EXMEM_OUT_RegDstOutput  out  5  EX/MEM register.
- dataMemoryOutput  out  32  MEM read data.
- branchGateOutput  out  1  MEM branch-taken signal.
- PIPE_MEMWB_OUT_CSignal_MemtoReg, _RegWrite  out  1  MEM/WB register.
- PIPE_MEMWB_DataMemoryOutput, PIPE_MEMWB_MainALUOutput  out  32  MEM/WB register.
- PIPE_MEMWB_RegDstOutput  out  5  MEM/WB register.
- memtoRegOutput  out  32  WB write data.

## Operation
- Supported instructions:
  - R-type (op 0): funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt.
  - lw (0x23), sw (0x2B), beq (0x04).
  - Any other opcode decodes to all-zero control (no-op).
- Decoder output order is RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp:
  - R-type: 1,0,0,1,0,0,0,10.
  - lw: 0,1,1,1,1,0,0,00.
  - sw: 0,1,0,0,0,1,0,00.
  - beq: 0,0,0,0,0,0,1,01.
- ALU control:
  - ALUOp 00 gives add (0010); ALUOp 01 gives sub (0110).
  - ALUOp 10 decodes funct: and 0000, or 0001, add 0010, sub 0110, slt 0111.
- ALU: slt is a signed compare giving 1 or 0. zero = (mainALUOutput == 0). Arithmetic wraps at 32 bits.
- EX datapath:
  - sllOutput = SignExt<<2; branchALUOutput = IDEX PC+4 + sllOutput.
  - ALUSrcOutput = ALUSrc ? SignExt : forwardingMUXALUi1.
  - regDstOutput = RegDst ? RD : RT.
- Forwarding (A shown; B uses RT identically):
  - 10 when EXMEM RegWrite, EXMEM dst != 0 and EXMEM dst == IDEX RS; the source is EXMEM MainALUOutput.
  - Otherwise 01 when MEMWB RegWrite, MEMWB dst != 0 and MEMWB dst == IDEX RS; the source is memtoRegOutput.
  - Otherwise 00, the source is the ID/EX read data.
- Load-use hazard:
  - Condition: IDEX MRead and IDEX RT equals IF/ID rs or rt.
  - Response: PCWrite=0, IF_ID_Write=0, MUX_ID_EX_Write=1; a zero-control bubble enters ID/EX.
  - Otherwise PCWrite=1, IF_ID_Write=1, MUX_ID_EX_Write=0.
- Branch:
  - branchGateOutput = EXMEM Branch & EXMEM Zero.
  - When 1, the next PC is EXMEM BranchALUOutput and IF/ID, ID/EX and EX/MEM are flushed to zero on that edge.
  - Otherwise the next PC is PC+4.
- Register file:
  - 32x32; $0 always reads 0.
  - Written on the rising edge when MEMWB RegWrite and dst != 0.
  - Reads are combinational, with internal write-through bypass when the WB destination equals the read register.
- Data memory:
  - Write on the rising edge when EXMEM MWrite.
  - Combinational read when EXMEM MRead; dataMemoryOutput is 0 otherwise.
- WB: memtoRegOutput = MEMWB MemtoReg ? DataMemoryOutput : MainALUOutput.

## Timing
- Reset (resetManual=0), applied asynchronously:
  - PC=0.
  - All pipeline registers 0.
  - Register i = i for i = 0..31.
  - Data memory is not affected by reset.
  - Instruction memory is loaded before simulation start, and unloaded words read as 0.
- Reset wins over all other activity, including a mid-stall or mid-branch state.
- Latency: an instruction fetched at edge n writes back at edge n+4.
- A load followed by a dependent instruction costs one stall cycle.
- A taken beq costs three flushed slots.
- A stall and a taken branch in the same cycle: the branch wins.

## Test plan
- Reset held, then released: PCOutput=0 and every PIPE_* output is 0. After the first edge, PCOutput=4.
- add r3,r1,r2: four edges after fetch, memtoRegOutput=3 with PIPE_MEMWB_RegDstOutput=3. readData1 of a later read of r3 returns 3.
- add r3,r1,r2 followed by sub r4,r3,r1: ForwardA=10 in the sub's EX cycle, and mainALUOutput=2.
- lw r5,0(r0) (mem[0]=7) followed by add r6,r5,r1:
  - One cycle with PCWrite=0, IF_ID_Write=0, MUX_ID_EX_Write=1.
  - Then ForwardA=01 and mainALUOutput=8.
- sw r2,4(r0) then lw r7,4(r0): dataMemoryOutput=2 and r7=2.
- beq r1,r1,+2 at PC 0:
  - branchGateOutput=1 in its MEM cycle.
  - PCOutput=12 on the next edge, and the three younger slots are zeroed.
